// File: rtl/pc_seq_pkg.sv
// Shared opcodes, FSM states and CCR flag positions for the EV22G5 PC sequencer.
package pc_seq_pkg;

  localparam logic [11:0] OP_JMP = 12'h800;
  localparam logic [11:0] OP_JZE = 12'h801;
  localparam logic [11:0] OP_JNE = 12'h802;
  localparam logic [11:0] OP_JCY = 12'h803;
  localparam logic [11:0] OP_RET = 12'h804;
  localparam logic [11:0] OP_BSR = 12'h805;
  localparam logic [11:0] OP_JSR = 12'h806;

  localparam int CCR_CY = 0;
  localparam int CCR_Z  = 2;
  localparam int CCR_N  = 3;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    COND  = 2'd2
  } state_e;

  // Which flag a pending conditional jump is waiting on.
  typedef enum logic [1:0] {
    CK_Z  = 2'd0,
    CK_N  = 2'd1,
    CK_CY = 2'd2
  } cond_e;

  function automatic logic cond_flag(input cond_e kind, input logic [3:0] ccr);
    case (kind)
      CK_Z:    return ccr[CCR_Z];
      CK_N:    return ccr[CCR_N];
      default: return ccr[CCR_CY];
    endcase
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Bounded LIFO of return addresses; pushes when full and pops when empty are ignored.
module pc_ret_stack #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  din,
  output logic [ADDR_W-1:0]                  dout,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   level
);

  localparam int LVL_W = $clog2(STACK_DEPTH+1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [LVL_W-1:0]  level_q;
  logic [PTR_W-1:0]  top_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (level_q == LVL_W'(STACK_DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !push && !empty;
  assign top_idx = PTR_W'(level_q - 1'b1);
  assign dout    = empty ? '0 : mem_q[top_idx];
  assign level   = level_q;

  // Entry storage needs no reset: only slots below level_q are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[PTR_W'(level_q)] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (do_push) begin
      level_q <= level_q + 1'b1;
    end else if (do_pop) begin
      level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: decodes the IR opcode into the next fetch address,
// with flag-conditional jumps (one stall cycle) and stacked subroutine calls.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int INSTR_W     = 24,
  parameter int OPC_W       = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [INSTR_W-1:0]               ir,
  input  logic [3:0]                       ccr,
  output logic [ADDR_W-1:0]                pc_output,
  output logic                             stall,
  output logic                             stack_ovf,
  output logic                             stack_unf,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level
);

  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              is_call;
  logic              is_ret;
  logic              push;
  logic              pop;

  state_e            state_q;
  cond_e             cond_q;
  logic [ADDR_W-1:0] pc_q;
  logic              stall_q;
  logic              ovf_q;
  logic              unf_q;

  assign opc     = ir[INSTR_W-1 -: OPC_W];
  assign tgt     = ir[ADDR_W-1:0];
  assign pc_inc  = pc_q + 1'b1;
  assign is_call = (opc == OPC_W'(OP_BSR)) || (opc == OPC_W'(OP_JSR));
  assign is_ret  = (opc == OPC_W'(OP_RET));
  assign push    = enable && (state_q == RUN) && is_call;
  assign pop     = enable && (state_q == RUN) && is_ret;

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .level (stack_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START;
      cond_q  <= CK_Z;
      pc_q    <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (enable) begin
      case (state_q)
        START: state_q <= RUN;
        RUN: begin
          case (opc)
            OPC_W'(OP_JMP): pc_q <= tgt;
            OPC_W'(OP_JZE): begin cond_q <= CK_Z;  state_q <= COND; stall_q <= 1'b1; end
            OPC_W'(OP_JNE): begin cond_q <= CK_N;  state_q <= COND; stall_q <= 1'b1; end
            OPC_W'(OP_JCY): begin cond_q <= CK_CY; state_q <= COND; stall_q <= 1'b1; end
            OPC_W'(OP_RET): begin
              pc_q <= stk_empty ? pc_inc : stk_top;
              if (stk_empty) unf_q <= 1'b1;
            end
            // Relative offset is the full-width target, so plain wrap-around
            // addition is the sign-extended branch.
            OPC_W'(OP_BSR): begin
              pc_q <= pc_q + tgt;
              if (stk_full) ovf_q <= 1'b1;
            end
            OPC_W'(OP_JSR): begin
              pc_q <= tgt;
              if (stk_full) ovf_q <= 1'b1;
            end
            default: pc_q <= pc_inc;
          endcase
        end
        COND: begin
          pc_q    <= cond_flag(cond_q, ccr) ? tgt : pc_inc;
          stall_q <= 1'b0;
          state_q <= RUN;
        end
        default: state_q <= START;
      endcase
    end
  end

  assign pc_output = pc_q;
  assign stall     = stall_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: a queue/integer reference model predicts each
// enabled-edge result; a monitor compares after every clock edge.
module tb_pc_seq_unit;

  localparam int ADDR_W      = 12;
  localparam int INSTR_W     = 24;
  localparam int OPC_W       = 12;
  localparam int STACK_DEPTH = 8;
  localparam int LVL_W       = $clog2(STACK_DEPTH+1);
  localparam int AMOD        = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic [INSTR_W-1:0]  ir;
  logic [3:0]          ccr;
  logic [ADDR_W-1:0]   pc_output;
  logic                stall;
  logic                stack_ovf;
  logic                stack_unf;
  logic [LVL_W-1:0]    stack_level;

  always #5 clk = ~clk;

  pc_seq_unit #(
    .ADDR_W      (ADDR_W),
    .INSTR_W     (INSTR_W),
    .OPC_W       (OPC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ir          (ir),
    .ccr         (ccr),
    .pc_output   (pc_output),
    .stall       (stall),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf),
    .stack_level (stack_level)
  );

  typedef struct {
    int pc;
    bit stall;
    bit ovf;
    bit unf;
    int level;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;

  // Reference model: 0 = waiting for first edge, 1 = decoding, 2 = awaiting flags.
  int   m_mode;
  int   m_pc;
  int   m_stack[$];
  bit   m_ovf;
  bit   m_unf;
  int   m_copc;

  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic logic [INSTR_W-1:0] op(int opc, int tgt);
    logic [11:0] o;
    logic [11:0] t;
    o = 12'(opc);
    t = 12'(tgt);
    return {o, t};
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_stack.delete();
    m_ovf  = 0;
    m_unf  = 0;
    m_copc = 0;
  endfunction

  function automatic void model_call(int next_pc);
    if (m_stack.size() < STACK_DEPTH) m_stack.push_back((m_pc + 1) % AMOD);
    else m_ovf = 1;
    m_pc = next_pc;
  endfunction

  function automatic void model_step(bit en, logic [INSTR_W-1:0] i, logic [3:0] c);
    int opc;
    int tgt;
    int off;
    bit flag;
    opc = int'(i[INSTR_W-1 -: OPC_W]);
    tgt = int'(i[ADDR_W-1:0]);
    off = (tgt >= AMOD/2) ? tgt - AMOD : tgt;
    if (!en) return;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        case (opc)
          'h800: m_pc = tgt;
          'h801, 'h802, 'h803: begin m_mode = 2; m_copc = opc; end
          'h804: begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = (m_pc + 1) % AMOD; m_unf = 1; end
          end
          'h805: model_call(((m_pc + off) % AMOD + AMOD) % AMOD);
          'h806: model_call(tgt);
          default: m_pc = (m_pc + 1) % AMOD;
        endcase
      end
      default: begin
        flag = (m_copc == 'h801) ? c[2] : (m_copc == 'h802) ? c[3] : c[0];
        m_pc = flag ? tgt : (m_pc + 1) % AMOD;
        m_mode = 1;
      end
    endcase
  endfunction

  // Drive one cycle from a falling edge, predict the result of the next rising edge.
  task automatic step(bit en, logic [INSTR_W-1:0] i, logic [3:0] c);
    exp_t e;
    enable = en;
    ir     = i;
    ccr    = c;
    model_step(en, i, c);
    e.pc    = m_pc;
    e.stall = (m_mode == 2);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.level = m_stack.size();
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      check("pc_output", int'(pc_output), e.pc);
      check("stall", int'(stall), int'(e.stall));
      check("stack_ovf", int'(stack_ovf), int'(e.ovf));
      check("stack_unf", int'(stack_unf), int'(e.unf));
      check("stack_level", int'(stack_level), e.level);
      $display("[TB] txn %0d pc=%03h stall=%0b lvl=%0d ovf=%0b unf=%0b",
               txn, pc_output, stall, stack_level, stack_ovf, stack_unf);
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    ir     = '0;
    ccr    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pc", int'(pc_output), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_level", int'(stack_level), 0);
    check("rst_errs", int'({stack_ovf, stack_unf}), 0);
    rst_n = 1'b1;

    repeat (4) step(1'b1, '0, 4'b0000);
    check("seq_pc3", int'(pc_output), 3);
    repeat (2) step(1'b1, '0, 4'b0000);

    // JZE 0x2A at pc 5, taken then not taken.
    step(1'b1, op('h801, 'h02A), 4'b0100);
    check("jze_stall", int'(stall), 1);
    check("jze_hold_pc", int'(pc_output), 5);
    step(1'b1, op('h801, 'h02A), 4'b0100);
    check("jze_taken", int'(pc_output), 'h02A);
    step(1'b1, op('h800, 5), 4'b0000);
    step(1'b1, op('h801, 'h02A), 4'b0000);
    step(1'b1, op('h801, 'h02A), 4'b0000);
    check("jze_not_taken", int'(pc_output), 6);

    // JNE / JCY flag selection.
    step(1'b1, op('h802, 'h0AA), 4'b0111);
    step(1'b1, op('h802, 'h0AA), 4'b0111);
    step(1'b1, op('h803, 'h0BB), 4'b0001);
    step(1'b1, op('h803, 'h0BB), 4'b0001);
    check("jcy_taken", int'(pc_output), 'h0BB);

    // JSR then RET.
    step(1'b1, op('h800, 'h010), 4'b0000);
    step(1'b1, op('h806, 'h100), 4'b0000);
    check("jsr_pc", int'(pc_output), 'h100);
    check("jsr_level", int'(stack_level), 1);
    step(1'b1, op('h804, 0), 4'b0000);
    check("ret_pc", int'(pc_output), 'h011);
    check("ret_level", int'(stack_level), 0);

    // BSR backwards, and forward across the wrap.
    step(1'b1, op('h800, 3), 4'b0000);
    step(1'b1, op('h805, 'hFFE), 4'b0000);
    check("bsr_back_pc", int'(pc_output), 1);
    step(1'b1, op('h804, 0), 4'b0000);
    check("bsr_pushed", int'(pc_output), 4);
    step(1'b1, op('h800, 'hFFF), 4'b0000);
    step(1'b1, op('h805, 2), 4'b0000);
    check("bsr_wrap_pc", int'(pc_output), 1);
    step(1'b1, op('h804, 0), 4'b0000);
    check("ret_wrap_pc", int'(pc_output), 0);

    // Overflow then full unwind plus one underflow.
    for (int k = 0; k <= STACK_DEPTH; k++) step(1'b1, op('h806, 'h100 + k*16), 4'b0000);
    check("ovf_flag", int'(stack_ovf), 1);
    check("ovf_level", int'(stack_level), STACK_DEPTH);
    check("ovf_pc", int'(pc_output), 'h180);
    for (int k = 0; k <= STACK_DEPTH; k++) step(1'b1, op('h804, 0), 4'b0000);
    check("unf_flag", int'(stack_unf), 1);
    check("unf_level", int'(stack_level), 0);
    check("unf_pc", int'(pc_output), 2);

    // Randomised traffic; ir is held while a conditional waits for evaluation.
    for (int n = 0; n < 400; n++) begin
      logic [INSTR_W-1:0] ri;
      bit en;
      int r;
      en = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 9);
      if (m_mode == 2) ri = ir;
      else ri = op((r < 8) ? 'h800 + r : $urandom_range(0, 4095), $urandom_range(0, 4095));
      step(en, ri, 4'($urandom_range(0, 15)));
    end
    if (m_mode == 2) step(1'b1, ir, 4'b0000);

    // Stall held with enable low, then asynchronous reset mid-COND.
    step(1'b1, op('h801, 'h055), 4'b0000);
    repeat (3) step(1'b0, op('h801, 'h055), 4'b0100);
    check("cond_held_stall", int'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_pc", int'(pc_output), 0);
    check("async_rst_stall", int'(stall), 0);
    check("async_rst_level", int'(stack_level), 0);
    check("async_rst_errs", int'({stack_ovf, stack_unf}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, op('h801, 'h055), 4'b0100);
    check("post_rst_start", int'(pc_output), 0);
    step(1'b1, '0, 4'b0000);
    check("post_rst_run", int'(pc_output), 1);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
